// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared constants, FSM states and trace entry layout for the CPU trace monitor
package cpu_trace_pkg;

    localparam logic [1:0] TRC_REG  = 2'b00;
    localparam logic [1:0] TRC_MEM  = 2'b01;
    localparam logic [1:0] TRC_HALT = 2'b10;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_LOOP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int TRC_PC_W   = 32;
    localparam int TRC_ADDR_W = 8;
    localparam int TRC_DATA_W = 32;

    // Default-width entry layout; the monitor redeclares it with its own parameter widths.
    typedef struct packed {
        logic [1:0]            kind;
        logic [TRC_PC_W-1:0]   pc;
        logic [TRC_ADDR_W-1:0] addr;
        logic [TRC_DATA_W-1:0] data;
    } trc_entry_t;

endpackage

// File: rtl/trace_ring_buf.sv
// rtl/trace_ring_buf.sv - multi-write, single-read circular buffer with drop or overwrite on full
module trace_ring_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int NW    = 3,
    parameter int WRAP  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [NW-1:0]        wr_en_i,
    input  logic [NW-1:0][W-1:0] wr_data_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [W-1:0]         rd_data_o,
    output logic                 overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    assign rd_valid_o = (cnt_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[head_q] : '0;
    assign overflow_o = ovf_q;

    // The pop is applied before the writes so a full buffer being drained accepts one more entry.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (rd_valid_o && rd_ready_i) begin
            head_d = head_d + ONE_P;
            cnt_d  = cnt_d - ONE_C;
        end
        for (int i = 0; i < NW; i++) begin
            if (wr_en_i[i]) begin
                if (cnt_d != FULL) begin
                    mem_d[tail_d] = wr_data_i[i];
                    tail_d        = tail_d + ONE_P;
                    cnt_d         = cnt_d + ONE_C;
                end else begin
                    ovf_d = 1'b1;
                    if (WRAP != 0) begin
                        mem_d[tail_d] = wr_data_i[i];
                        tail_d        = tail_d + ONE_P;
                        head_d        = head_d + ONE_P;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - CPU execution monitor with on-chip trace buffer and end-of-run detection
// Define CPU_TRACE_MEM_EN to capture data-memory writes as trace entries.
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 30,
    parameter int HALT_REPEAT = 3,
    parameter int WRAP        = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              retire_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              rf_we_i,
    input  logic [4:0]        rf_addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              trc_valid_o,
    input  logic              trc_ready_i,
    output logic [1:0]        trc_kind_o,
    output logic [PC_W-1:0]   trc_pc_o,
    output logic [ADDR_W-1:0] trc_addr_o,
    output logic [DATA_W-1:0] trc_data_o,
    output logic              running_o,
    output logic              halted_o,
    output logic              overflow_o,
    output logic [1:0]        halt_cause_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  instr_cnt_o
);

    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    typedef struct packed {
        logic [1:0]        kind;
        logic [PC_W-1:0]   pc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [1:0]       cause_q, cause_d;
    logic [2:0]       wr_en;
    entry_t [2:0]     wr_ent;
    entry_t           head;
    logic             hit_budget, hit_loop;

`ifndef CPU_TRACE_MEM_EN
    logic unused_dm;
    assign unused_dm = ^{dm_we_i, dm_addr_i, dm_data_i};
`endif

    // rep_q starts at 0 so the first retirement of a run yields 1 whether or not its PC matches.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        ins_d      = ins_q;
        last_pc_d  = last_pc_q;
        rep_d      = rep_q;
        cause_d    = cause_q;
        wr_en      = '0;
        wr_ent     = '0;
        hit_budget = 1'b0;
        hit_loop   = 1'b0;
        if (start_i) begin
            state_d   = RUN;
            cyc_d     = '0;
            ins_d     = '0;
            last_pc_d = '0;
            rep_d     = '0;
            cause_d   = CAUSE_NONE;
        end else if (state_q == RUN) begin
            if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
            if (retire_i) begin
                if (ins_q != '1) ins_d = ins_q + CNT_W'(1);
                rep_d     = (pc_i == last_pc_q) ? rep_q + RW'(1) : RW'(1);
                last_pc_d = pc_i;
                hit_loop  = (rep_d == RW'(HALT_REPEAT));
            end
            hit_budget = (MAX_CYCLES != 0) && (cyc_d == MAX_C);
            wr_en[0]  = rf_we_i && (rf_addr_i != 5'd0);
            wr_ent[0] = '{kind: TRC_REG, pc: pc_i, addr: ADDR_W'(rf_addr_i), data: rf_data_i};
`ifdef CPU_TRACE_MEM_EN
            wr_en[1]  = dm_we_i;
            wr_ent[1] = '{kind: TRC_MEM, pc: pc_i, addr: dm_addr_i, data: dm_data_i};
`endif
            if (hit_budget || hit_loop) begin
                wr_en[2]  = 1'b1;
                wr_ent[2] = '{kind: TRC_HALT, pc: pc_i, addr: '0, data: DATA_W'(cyc_d)};
                cause_d   = hit_budget ? CAUSE_BUDGET : CAUSE_LOOP;
                state_d   = HALTED;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            ins_q     <= '0;
            last_pc_q <= '0;
            rep_q     <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
            cause_q   <= cause_d;
        end
    end

    trace_ring_buf #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH),
        .NW    (3),
        .WRAP  (WRAP)
    ) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (start_i),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_ent),
        .rd_ready_i (trc_ready_i),
        .rd_valid_o (trc_valid_o),
        .rd_data_o  (head),
        .overflow_o (overflow_o)
    );

    assign trc_kind_o   = head.kind;
    assign trc_pc_o     = head.pc;
    assign trc_addr_o   = head.addr;
    assign trc_data_o   = head.data;
    assign running_o    = (state_q == RUN);
    assign halted_o     = (state_q == HALTED);
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cyc_q;
    assign instr_cnt_o  = ins_q;

endmodule
